// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the program counter, addresses the RAM
//   fetch port with it, captures the returned word into a small instruction
//   buffer and presents buffered words to decode over a valid/ready
//   handshake. Handles branch redirects, a halt opcode and restart.
//
//   Build option: FETCH_PREFETCH_BUF_EN
//     defined   -> 2-entry prefetch FIFO (fetch runs ahead while decode stalls)
//     undefined -> single-entry buffer register
//
// Ports
//   clk            in   1   rising-edge clock
//   reset_n        in   1   synchronous active-low reset
//   start          in   1   begin / restart fetching at RESET_PC
//   fetch_address  out  16  RAM fetch address (the PC register)
//   fetch_data     in   32  RAM word for fetch_address, same cycle
//   instr_out      out  32  buffer head instruction
//   instr_pc       out  16  address the head instruction came from
//   instr_valid    out  1   buffer non-empty
//   instr_ready    in   1   decode accepts the head this cycle
//   branch_valid   in   1   redirect request
//   branch_target  in   16  redirect address
//   halted         out  1   fetch stopped on a halt opcode
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [15:0] fetch_address,
    input  logic [31:0] fetch_data,
    output logic [31:0] instr_out,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        halted
);

`ifdef FETCH_PREFETCH_BUF_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] instr_q [DEPTH];
    logic [31:0] instr_d [DEPTH];
    logic [15:0] ipc_q   [DEPTH];
    logic [15:0] ipc_d   [DEPTH];

    logic       pop;
    logic       space;
    logic [1:0] fill;
    logic       halt_word;

    assign pop       = (count_q != 2'd0) && instr_ready;
    // A slot is free either now or because the head leaves on this edge.
    assign space     = (count_q < DEPTH_C) || pop;
    assign fill      = count_q - 2'(pop);
    assign halt_word = (fetch_data[27:24] == HALT_OPCODE);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;

        if (start) begin
            // Restart wins over a simultaneous branch; buffer is flushed.
            state_d = RUN;
            pc_d    = RESET_PC;
            count_d = 2'd0;
        end else if (branch_valid && (state_q != IDLE)) begin
            // A head handshaking this cycle is already consumed by decode;
            // everything else, including this cycle's fetch_data, is dropped.
            state_d = RUN;
            pc_d    = branch_target;
            count_d = 2'd0;
        end else begin
            if (pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    instr_d[i] = instr_q[i+1];
                    ipc_d[i]   = ipc_q[i+1];
                end
                count_d = fill;
            end
            if ((state_q == RUN) && space) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (i == int'(fill)) begin
                        instr_d[i] = fetch_data;
                        ipc_d[i]   = pc_q;
                    end
                end
                count_d = fill + 2'd1;
                if (halt_word) begin
                    // PC parks on the halt word's own address.
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= 32'd0;
                ipc_q[i]   <= 16'd0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    assign fetch_address = pc_q;
    assign instr_out     = instr_q[0];
    assign instr_pc      = ipc_q[0];
    assign instr_valid   = (count_q != 2'd0);
    assign halted        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_BUF_EN
    localparam int MDEPTH = 2;
`else
    localparam int MDEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] fetch_address;
    logic [31:0] fetch_data;
    logic [31:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        halted;

    logic halt_en;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   cmp_en   = 1'b0;

    always #5 clk = ~clk;

    // RAM contents: E1000000+addr, optionally a halt word at address 3.
    function automatic logic [31:0] ram(input logic [15:0] a);
        if (halt_en && a == 16'd3) return 32'hEF000000;
        return 32'hE1000000 + {16'd0, a};
    endfunction

    assign fetch_data = ram(fetch_address);

    fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .fetch_address(fetch_address),
        .fetch_data   (fetch_data),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .halted       (halted)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] ins;
        logic [15:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc      = 16'h0000;
    bit          m_running = 1'b0;
    bit          m_stopped = 1'b0;

    always @(posedge clk) begin
        logic [31:0] w;
        if (!reset_n) begin
            mq.delete();
            m_pc = 16'h0000; m_running = 0; m_stopped = 0;
        end else if (start) begin
            mq.delete();
            m_pc = 16'h0000; m_running = 1; m_stopped = 0;
        end else if (branch_valid && (m_running || m_stopped)) begin
            mq.delete();
            m_pc = branch_target; m_running = 1; m_stopped = 0;
        end else begin
            if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
            if (m_running && mq.size() < MDEPTH) begin
                w = ram(m_pc);
                mq.push_back('{ins: w, pc: m_pc});
                if (w[27:24] == 4'hF) begin
                    m_running = 0; m_stopped = 1;
                end else begin
                    m_pc = m_pc + 16'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("fetch_address", {16'd0, fetch_address}, {16'd0, m_pc});
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, (mq.size() != 0)});
            chk("halted", {31'd0, halted}, {31'd0, m_stopped});
            if (mq.size() != 0 && instr_valid) begin
                chk("instr_out", instr_out, mq[0].ins);
                chk("instr_pc", {16'd0, instr_pc}, {16'd0, mq[0].pc});
            end
        end
    end

    // Apply inputs, then return just after the edge that samples them.
    task automatic tick(input logic rn, input logic s, input logic b,
                        input logic [15:0] t, input logic r);
        reset_n = rn; start = s; branch_valid = b; branch_target = t; instr_ready = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 0; start = 0; branch_valid = 0; branch_target = 0;
        instr_ready = 0; halt_en = 0;
        tick(0, 0, 0, 16'h0, 0);
        tick(0, 0, 0, 16'h0, 0);
        cmp_en = 1'b1;
        // Reset state
        chk("rst_fetch_address", {16'd0, fetch_address}, 32'h0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'h0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_instr_pc", {16'd0, instr_pc}, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'h0);

        // Branch in IDLE is ignored
        tick(1, 0, 1, 16'h0055, 1);
        chk("idle_branch_ignored", {16'd0, fetch_address}, 32'h0);
        tick(1, 0, 0, 16'h0, 1);
        chk("idle_no_capture", {31'd0, instr_valid}, 32'h0);

        // Basic fetch
        tick(1, 1, 0, 16'h0, 1);
        chk("start_addr", {16'd0, fetch_address}, 32'h0);
        chk("start_not_valid", {31'd0, instr_valid}, 32'h0);
        tick(1, 0, 0, 16'h0, 1);
        chk("first_pc", {16'd0, instr_pc}, 32'h0);
        chk("first_instr", instr_out, 32'hE1000000);
        tick(1, 0, 0, 16'h0, 1);
        chk("second_pc", {16'd0, instr_pc}, 32'h1);
        for (int k = 0; k < 5; k++) tick(1, 0, 0, 16'h0, 1);
        chk("seventh_instr", instr_out, 32'hE1000006);

        // Stall then branch with head handshake
        tick(1, 1, 0, 16'h0, 0);
        tick(1, 0, 0, 16'h0, 0);
        for (int k = 0; k < 5; k++) tick(1, 0, 0, 16'h0, 0);
        chk("stall_freeze", {16'd0, fetch_address}, MDEPTH);
        chk("stall_head", {16'd0, instr_pc}, 32'h0);
        tick(1, 0, 1, 16'h0040, 1);
        chk("branch_addr", {16'd0, fetch_address}, 32'h0040);
        chk("branch_flush", {31'd0, instr_valid}, 32'h0);
        tick(1, 0, 0, 16'h0, 1);
        chk("branch_target_pc", {16'd0, instr_pc}, 32'h0040);
        chk("branch_target_instr", instr_out, 32'hE1000040);

        // Stall then release: no loss or duplication
        tick(1, 1, 0, 16'h0, 0);
        tick(1, 0, 0, 16'h0, 0);
        for (int k = 0; k < 5; k++) tick(1, 0, 0, 16'h0, 0);
        tick(1, 0, 0, 16'h0, 1);
        chk("release_pc", {16'd0, instr_pc}, 32'h1);
        tick(1, 0, 0, 16'h0, 1);
        chk("release_pc2", {16'd0, instr_pc}, 32'h2);
        for (int k = 0; k < 3; k++) tick(1, 0, 0, 16'h0, 1);

        // Halt
        halt_en = 1;
        tick(1, 1, 0, 16'h0, 1);
        for (int k = 0; k < 4; k++) tick(1, 0, 0, 16'h0, 1);
        chk("halt_pc", {16'd0, instr_pc}, 32'h3);
        chk("halt_instr", instr_out, 32'hEF000000);
        chk("halt_flag", {31'd0, halted}, 32'h1);
        chk("halt_addr", {16'd0, fetch_address}, 32'h3);
        tick(1, 0, 0, 16'h0, 1);
        tick(1, 0, 0, 16'h0, 1);
        chk("halt_park", {16'd0, fetch_address}, 32'h3);
        chk("halt_drained", {31'd0, instr_valid}, 32'h0);
        tick(1, 0, 1, 16'h0010, 1);
        chk("resume_flag", {31'd0, halted}, 32'h0);
        tick(1, 0, 0, 16'h0, 1);
        chk("resume_pc", {16'd0, instr_pc}, 32'h0010);
        halt_en = 0;

        // Wrap
        tick(1, 0, 1, 16'hFFFE, 1);
        tick(1, 0, 0, 16'h0, 1);
        chk("wrap_fffe", {16'd0, instr_pc}, 32'hFFFE);
        tick(1, 0, 0, 16'h0, 1);
        chk("wrap_ffff", {16'd0, instr_pc}, 32'hFFFF);
        tick(1, 0, 0, 16'h0, 1);
        chk("wrap_0000", {16'd0, instr_pc}, 32'h0000);

        // start and branch together: start wins
        for (int k = 0; k < 3; k++) tick(1, 0, 0, 16'h0, 1);
        tick(1, 1, 1, 16'h0077, 1);
        chk("start_wins", {16'd0, fetch_address}, 32'h0);
        for (int k = 0; k < 3; k++) tick(1, 0, 0, 16'h0, 0);

        // Reset mid-run with start and branch high
        tick(0, 1, 1, 16'h0033, 1);
        chk("mrst_addr", {16'd0, fetch_address}, 32'h0);
        chk("mrst_valid", {31'd0, instr_valid}, 32'h0);
        chk("mrst_instr", instr_out, 32'h0);
        chk("mrst_pc", {16'd0, instr_pc}, 32'h0);
        chk("mrst_halted", {31'd0, halted}, 32'h0);
        tick(1, 0, 0, 16'h0, 1);
        tick(1, 0, 0, 16'h0, 1);
        chk("mrst_idle", {31'd0, instr_valid}, 32'h0);
        chk("mrst_idle_addr", {16'd0, fetch_address}, 32'h0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
